signed_frac_div: RTL and testbench
==================================

Name: signed_frac_div

Overview:
- Iterative signed Q1.7 fractional divider; the inverse operation of the team's combinational Q1.7 multiplier.
- Computes out = a / b in Q1.7, so that out multiplied by b is approximately a.
- Used where datapaths need gain normalisation or ratio computation without a DSP-heavy combinational divider.
- Radix-2 restoring algorithm, one quotient bit per clock, start/busy/out_valid handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; format is Q1.(WIDTH-1), two's complement.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  signed dividend, Q1.(WIDTH-1)
- b  input  WIDTH  signed divisor, Q1.(WIDTH-1)
- busy  output  1  division in progress; start ignored while high
- out_valid  output  1  one-cycle pulse, result valid
- out  output  WIDTH  signed quotient, Q1.(WIDTH-1); held until next result
- ovf  output  1  result saturated (|a/b| not representable); qualified by out_valid, held with out
- div0  output  1  b was zero; qualified by out_valid, held with out

Behaviour:
- Reset, asynchronous, rst_n=0: state IDLE; busy=0, out_valid=0, out=0, ovf=0, div0=0; internal registers cleared.
- Reset asserted mid-operation aborts the operation; no out_valid is produced.
- Let F = WIDTH-1. Result is the magnitude quotient q = floor(|a|*2^F / |b|), with the sign applied: negative iff sign(a) XOR sign(b) and q != 0. Truncation is toward zero.
- All magnitudes are WIDTH bits unsigned, so |-2^F| = 2^F is representable.
- State IDLE:
  - start=1 at edge E0 registers |a|, |b|, the result sign and the flags.
  - Remainder r = |a|, q = 0; go to CALC; busy=1.
- State CALC, F cycles, edges E1..EF, for bit i = F-1 down to 0:
  - r = r<<1;
  - if r >= |b| then r = r - |b| and q[i] = 1.
  - The remainder register is WIDTH+1 bits.
- State FIN, edge E(F+1) = E(WIDTH):
  - Apply sign and saturation, register out, ovf and div0.
  - out_valid=1 for exactly one cycle; busy=0; return to IDLE.
- Fixed latency: out_valid is high in the cycle after edge E(WIDTH), i.e. 8 edges after the start edge for WIDTH=8. This holds for all cases, including saturation and div0.
- start may be high in the same cycle as out_valid; it is accepted, giving back-to-back throughput of one result per WIDTH+1 cycles.
- start while busy=1 is ignored; it is not queued.
- Saturation is decided at load time:
  - |a| > |b|: ovf=1; out = 2^F-1 if the result is positive, -2^F if negative.
  - |a| == |b| with b != 0: positive result gives out = 2^F-1 with ovf=1; negative result gives out = -2^F exactly with ovf=0.
  - b == 0: div0=1, ovf=0; out = 2^F-1 if a >= 0, else -2^F.
  - a == 0 with b != 0: out = 0, flags 0.
  - CALC still runs its F cycles in all these cases to keep latency fixed.
- ovf and div0 are never both 1.

Optional Feature:
- Macro: SIGNED_FRAC_DIV_ROUND_EN.
- Defined:
  - CALC runs F+1 cycles, producing one extra guard bit.
  - Magnitude is q = (q_ext + 1) >> 1, i.e. round half away from zero.
  - Latency becomes WIDTH+1 edges.
  - If |a| < |b| but the rounded q reaches 2^F: a positive result saturates to 2^F-1 with ovf=1; a negative result gives -2^F with ovf=0.
- Undefined: truncation toward zero, latency WIDTH edges.

Test Plan:
- a=0x20 (0.25), b=0x40 (0.5), start pulse -> after 8 edges out_valid=1, out=0x40, ovf=0, div0=0; busy high for the 8 intervening cycles.
- a=0x01, b=0x03 -> out=0x2A. a=0xFF, b=0x03 -> out=0xD6. With SIGNED_FRAC_DIV_ROUND_EN: 0x2B and 0xD5 respectively, latency 9 edges.
- Saturation cases, all at the same latency:
  - a=0x40, b=0x20 -> out=0x7F, ovf=1.
  - a=0x40, b=0xC0 -> out=0x80, ovf=0.
  - a=0x80, b=0x80 -> out=0x7F, ovf=1.
- Divide-by-zero cases: a=0x10, b=0x00 -> out=0x7F, div0=1, ovf=0. a=0xF0, b=0x00 -> out=0x80, div0=1.
- Handshake: start re-pulsed while busy with different operands -> ignored, first result returned. start asserted during the out_valid cycle -> second result exactly 9 cycles after the first.
- Reset: rst_n driven low at edge E4 of a division -> busy, out_valid, out, ovf and div0 drop to 0 immediately, no out_valid after release. A new division after reset completes correctly.

Source files
------------

// File: rtl/signed_frac_div.sv
// Iterative radix-2 restoring divider, signed Q1.(WIDTH-1); SIGNED_FRAC_DIV_ROUND_EN adds a guard bit and rounds half away from zero.
// Latency: out_valid pulses WIDTH edges after the start edge, or WIDTH+1 edges with SIGNED_FRAC_DIV_ROUND_EN.
// Backpressure: start is ignored while busy; no queueing; start in the out_valid cycle is accepted.
module signed_frac_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             div0
);
    localparam int F = WIDTH - 1;
`ifdef SIGNED_FRAC_DIV_ROUND_EN
    localparam int QW = WIDTH;
`else
    localparam int QW = F;
`endif
    localparam int CW = $clog2(QW + 1);
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {F{1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {F{1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   r_q;
    logic [QW-1:0]    q_q;
    logic [WIDTH-1:0] mag_b_q;
    logic             neg_q;
    logic             div0_pend_q;
    logic             ovf_pend_q;
    logic             full_q;
    logic             busy_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             ovf_q;
    logic             div0_q;

    logic [WIDTH-1:0] mag_a, mag_b, mag_res;
    logic [WIDTH+1:0] r_sh;
    logic             ge;
    logic             at_limit;
    logic [WIDTH-1:0] out_d;
    logic             ovf_d;
    logic             div0_d;

    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;
    assign r_sh  = {r_q, 1'b0};
    assign ge    = r_sh >= {2'b00, mag_b_q};

    always_comb begin
`ifdef SIGNED_FRAC_DIV_ROUND_EN
        // (q_ext + 1) >> 1 without a wider adder
        mag_res = {1'b0, q_q[QW-1:1]} + {{F{1'b0}}, q_q[0]};
`else
        mag_res = {1'b0, q_q};
`endif
        // |a| == |b| or a rounded-up quotient both give magnitude 2^F
        at_limit = full_q || (mag_res == NEG_MIN);
        out_d    = '0;
        ovf_d    = 1'b0;
        div0_d   = 1'b0;
        if (div0_pend_q) begin
            div0_d = 1'b1;
            out_d  = neg_q ? NEG_MIN : POS_MAX;
        end else if (ovf_pend_q) begin
            ovf_d = 1'b1;
            out_d = neg_q ? NEG_MIN : POS_MAX;
        end else if (at_limit) begin
            ovf_d = ~neg_q;
            out_d = neg_q ? NEG_MIN : POS_MAX;
        end else begin
            out_d = neg_q ? -mag_res : mag_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            mag_b_q     <= '0;
            neg_q       <= 1'b0;
            div0_pend_q <= 1'b0;
            ovf_pend_q  <= 1'b0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mag_b_q     <= mag_b;
                        r_q         <= {1'b0, mag_a};
                        q_q         <= '0;
                        neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
                        div0_pend_q <= (b == '0);
                        ovf_pend_q  <= (b != '0) && (mag_a > mag_b);
                        full_q      <= (b != '0) && (mag_a == mag_b);
                        cnt_q       <= CW'(QW - 1);
                        busy_q      <= 1'b1;
                        state_q     <= CALC;
                    end
                end
                CALC: begin
                    r_q <= ge ? (WIDTH+1)'(r_sh - {2'b00, mag_b_q}) : (WIDTH+1)'(r_sh);
                    q_q <= {q_q[QW-2:0], ge};
                    if (cnt_q == '0) state_q <= FIN;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                FIN: begin
                    out_q       <= out_d;
                    ovf_q       <= ovf_d;
                    div0_q      <= div0_d;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;
    assign div0      = div0_q;
endmodule

// File: tb/tb_signed_frac_div.sv
// Bench for signed_frac_div: directed test-plan vectors, handshake and reset scenarios, random operands vs an arithmetic model.
module tb_signed_frac_div;
`ifdef SIGNED_FRAC_DIV_ROUND_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [7:0] a, b, out;
    logic       busy, out_valid, ovf, div0;
    int         total = 0;
    int         bad = 0;

    signed_frac_div #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .out_valid(out_valid), .out(out), .ovf(ovf), .div0(div0)
    );

    always #5 clk = ~clk;

    function automatic void ref_div(input logic [7:0] ia, input logic [7:0] ib,
                                    output logic [7:0] ro, output logic rov, output logic rd0);
        int sa, sb, ma, mb, q;
        bit neg;
        sa  = int'($signed(ia));
        sb  = int'($signed(ib));
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        neg = (sa < 0) != (sb < 0);
        rov = 1'b0;
        rd0 = 1'b0;
        if (mb == 0) begin
            rd0 = 1'b1;
            ro  = (sa >= 0) ? 8'h7F : 8'h80;
        end else if (ma > mb) begin
            rov = 1'b1;
            ro  = neg ? 8'h80 : 8'h7F;
        end else begin
`ifdef SIGNED_FRAC_DIV_ROUND_EN
            q = ((ma * 256) / mb + 1) / 2;
`else
            q = (ma * 128) / mb;
`endif
            if (q >= 128) begin
                ro  = neg ? 8'h80 : 8'h7F;
                rov = !neg;
            end else begin
                ro = 8'(neg ? -q : q);
            end
        end
    endfunction

    // Issues one start pulse and returns edges from start edge to out_valid (bounded).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        busy_ok = busy;
        lat     = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid && !busy) busy_ok = 1'b0;
        end
        if (out_valid && busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        total++;
        if ({busy, out_valid, out, ovf, div0} !== 12'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=000", {busy, out_valid, out, ovf, div0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [7:0] ta[10], tbv[10], eo[10];
        logic       eov[10], ed0[10];
        int lat;
        bit bok;
        ta = '{8'h20, 8'h01, 8'hFF, 8'h40, 8'h40, 8'h80, 8'h10, 8'hF0, 8'h00, 8'h40};
        tbv = '{8'h40, 8'h03, 8'h03, 8'h20, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h55, 8'h40};
`ifdef SIGNED_FRAC_DIV_ROUND_EN
        eo = '{8'h40, 8'h2B, 8'hD5, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h00, 8'h7F};
`else
        eo = '{8'h40, 8'h2A, 8'hD6, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h00, 8'h7F};
`endif
        eov = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
        ed0 = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            run_op(ta[i], tbv[i], lat, bok);
            total++;
            if (lat !== LAT) begin
                bad++;
                $display("FAIL dir_latency a=%h b=%h got=%0d want=%0d", ta[i], tbv[i], lat, LAT);
            end
            total++;
            if ({out, ovf, div0} !== {eo[i], eov[i], ed0[i]}) begin
                bad++;
                $display("FAIL dir_result a=%h b=%h got out=%h ovf=%b div0=%b want out=%h ovf=%b div0=%b",
                         ta[i], tbv[i], out, ovf, div0, eo[i], eov[i], ed0[i]);
            end
            total++;
            if (!bok) begin
                bad++;
                $display("FAIL dir_busy a=%h b=%h got busy gap want busy high until result", ta[i], tbv[i]);
            end
            @(posedge clk); #1;
            total++;
            if ({out_valid, out, ovf, div0} !== {1'b0, eo[i], eov[i], ed0[i]}) begin
                bad++;
                $display("FAIL dir_hold got vld=%b out=%h want vld=0 out=%h", out_valid, out, eo[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] ra, rb, eo;
        logic       eov, ed0;
        logic [7:0] edges[6];
        int lat;
        bit bok;
        edges = '{8'h00, 8'h80, 8'h7F, 8'h01, 8'hFF, 8'h81};
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 8'($urandom);
            ref_div(ra, rb, eo, eov, ed0);
            run_op(ra, rb, lat, bok);
            total++;
            if ({lat == LAT, out, ovf, div0} !== {1'b1, eo, eov, ed0}) begin
                bad++;
                $display("FAIL rand a=%h b=%h got lat=%0d out=%h ovf=%b div0=%b want lat=%0d out=%h ovf=%b div0=%b",
                         ra, rb, lat, out, ovf, div0, LAT, eo, eov, ed0);
            end
        end
    endtask

    task automatic test_ignore_busy;
        logic [7:0] eo;
        logic       eov, ed0;
        int lat, extra;
        ref_div(8'h01, 8'h03, eo, eov, ed0);
        @(negedge clk);
        a = 8'h01; b = 8'h03; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        a = 8'h40; b = 8'h20; start = 1'b1;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        total++;
        if ({lat == LAT, out, ovf, div0} !== {1'b1, eo, eov, ed0}) begin
            bad++;
            $display("FAIL ignore_busy got lat=%0d out=%h ovf=%b want lat=%0d out=%h ovf=%b", lat, out, ovf, LAT, eo, eov);
        end
        extra = 0;
        repeat (LAT + 3) begin @(posedge clk); #1; if (out_valid || busy) extra++; end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ignore_queued got activity=%0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] eo;
        logic       eov, ed0;
        int lat, gap;
        bit bok;
        run_op(8'h20, 8'h40, lat, bok);
        // out_valid is high now; request the next division in this same cycle
        a = 8'hFF; b = 8'h03; start = 1'b1;
        ref_div(8'hFF, 8'h03, eo, eov, ed0);
        @(posedge clk); #1;
        start = 1'b0;
        gap = 1;
        while (!out_valid && gap < 40) begin @(posedge clk); #1; gap++; end
        total++;
        if (gap !== LAT + 1) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=%0d", gap, LAT + 1);
        end
        total++;
        if ({out, ovf, div0} !== {eo, eov, ed0}) begin
            bad++;
            $display("FAIL b2b_result got out=%h want out=%h", out, eo);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] eo;
        logic       eov, ed0;
        int lat, seen;
        bit bok;
        run_op(8'h10, 8'h00, lat, bok);
        @(negedge clk);
        a = 8'h01; b = 8'h03; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, out_valid, out, ovf, div0} !== 12'h0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=000", {busy, out_valid, out, ovf, div0});
        end
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (LAT + 4) begin @(posedge clk); #1; if (out_valid || busy) seen++; end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_abort got activity=%0d want 0", seen);
        end
        ref_div(8'hC0, 8'h40, eo, eov, ed0);
        run_op(8'hC0, 8'h40, lat, bok);
        total++;
        if ({lat == LAT, out, ovf, div0} !== {1'b1, eo, eov, ed0}) begin
            bad++;
            $display("FAIL reset_recover got lat=%0d out=%h ovf=%b want out=%h ovf=%b", lat, out, ovf, eo, eov);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_busy;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
